fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage of the 3-stage RV32I pipeline, directly upstream of the decode/execute pipeline register. Owns the PC and issues requests to instruction memory over a req/gnt/rvalid handshake. Presents {instruction, PC} plus a valid flag to decode. Handles stalls with a one-entry buffer, and handles branch/jalr redirects by squashing wrong-path fetches.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, instruction driven on a bubble (addi x0,x0,0)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-low reset
imem_req  out  1  fetch request valid
imem_addr  out  32  fetch address, word-aligned
imem_gnt  in  1  request accepted this cycle (req & gnt)
imem_rvalid  in  1  response data valid; at least 1 cycle after the grant
imem_rdata  in  32  fetched instruction
stall_in  in  1  decode cannot accept; hold outputs
redirect_valid  in  1  taken branch or jalr resolved in execute
redirect_addr  in  32  redirect target
valid_out  out  1  instruction_out/pre_address_out meaningful
instruction_out  out  32  fetched instruction (feeds instruction_in downstream)
pre_address_out  out  32  PC of instruction_out (feeds pre_address_in downstream)

Behaviour:
- Reset, sampled on posedge while rst=0:
  - pc=RESET_PC; FSM=ISSUE; kill=0; buf_valid=0.
  - valid_out=0, instruction_out=NOP_INSTR, pre_address_out=RESET_PC.
  - imem_req is driven 0 while rst=0.
  - Reset mid-transaction drops any outstanding response. A stale rvalid arriving after reset is ignored, because FSM=ISSUE does not accept rvalid.
- At most one outstanding request.
- FSM states:
  - ISSUE:
    - imem_req=1 when buf_valid=0; imem_addr=pc.
    - On gnt: go to WAIT; pc<=pc+4 (32-bit wrap, 0xFFFF_FFFC+4=0).
    - While buf_valid=1: imem_req=0 and stay in ISSUE.
  - WAIT:
    - imem_req=0.
    - On rvalid with kill=0: deliver data and go to ISSUE.
    - On rvalid with kill=1: discard data, clear kill, go to ISSUE.
- Delivery, on a cycle where an rvalid is accepted (address = the PC granted for that request):
  - stall_in=0 and buf_valid=0: output regs <= {1, rdata, addr}.
  - stall_in=1: capture into buffer (buf_valid=1); output regs hold.
- Stall:
  - While stall_in=1, valid_out, instruction_out and pre_address_out hold.
  - On the first cycle with stall_in=0 and buf_valid=1, the buffer moves to the outputs and buf_valid clears. The next request issues in that same cycle.
- Non-stall cycle with nothing delivered: valid_out<=0, instruction_out<=NOP_INSTR, pre_address_out holds.
- Redirect (highest priority, overrides stall):
  - pc <= {redirect_addr[31:2],2'b00}.
  - Outputs become a bubble next cycle; buf_valid<=0.
  - If FSM=WAIT and no rvalid this cycle: kill<=1.
  - If rvalid arrives in the same cycle as the redirect: discard it and go to ISSUE.
  - If in ISSUE with gnt in the same cycle: that grant's address is wrong-path. Go to WAIT with kill=1, and set pc to the target, not pc+4.
- Throughput with 1-cycle memory latency: one instruction per 2 cycles (ISSUE, WAIT).
- Latency: the first instruction after reset release appears on the outputs 1 cycle after its rvalid.

Test Plan:
- Reset release, gnt=1 always, rvalid 1 cycle after grant, rdata=addr^32'hA5A5_0000 → imem_addr sequence 0,4,8. Outputs {1,32'hA5A5_0000,0} then {1,32'hA5A5_0004,4}, with valid_out=0 on alternate cycles.
- stall_in=1 for 5 cycles while the response for PC 8 arrives → outputs hold the PC 4 instruction and imem_req=0 while the buffer is full. After stall drops: PC 8 instruction with valid_out=1, and the request for 12 issues the same cycle.
- redirect_valid=1, redirect_addr=32'h0000_0103 while in WAIT for PC 12 → the PC 12 response is discarded. Next imem_addr=32'h0000_0100; no output ever carries pre_address 12.
- redirect coincident with gnt for PC 16 → the wrong-path response is dropped. Next request is to the target; valid_out=0 until target data arrives.
- pc=32'hFFFF_FFFC granted → next imem_addr=32'h0000_0000.
- rst=0 asserted during WAIT, then rvalid pulses → outputs stay at reset values (NOP_INSTR, RESET_PC, valid 0). First request after release is RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32I instruction-fetch stage with one-entry stall buffer
// Owns the PC, keeps at most one imem request in flight and squashes wrong-path responses on redirect.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall_in,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  output logic        valid_out,
  output logic [31:0] instruction_out,
  output logic [31:0] pre_address_out
);

  typedef enum logic {S_ISSUE, S_WAIT} state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] req_pc;
  logic        kill, kill_next;
  logic        buf_valid;
  logic [31:0] buf_instr, buf_addr;
  logic        grant, accept, deliver;

  assign grant   = imem_req & imem_gnt;
  assign accept  = (state == S_WAIT) & imem_rvalid;
  assign deliver = accept & ~kill & ~redirect_valid;

  always_comb begin
    state_next = state;
    pc_next    = pc;
    kill_next  = kill;
    imem_req   = 1'b0;
    imem_addr  = pc;
    case (state)
      S_ISSUE: begin
        imem_req = rst & ~buf_valid;
        if (grant) begin
          state_next = S_WAIT;
          pc_next    = pc + 32'd4;
          kill_next  = 1'b0;
        end
      end
      S_WAIT: begin
        if (accept) begin
          state_next = S_ISSUE;
          kill_next  = 1'b0;
        end
      end
      default: state_next = S_ISSUE;
    endcase
    // A grant in the redirect cycle is wrong-path, as is any response still owed in WAIT.
    if (redirect_valid) begin
      pc_next = redirect_addr & 32'hFFFF_FFFC;
      if (state == S_ISSUE) kill_next = grant;
      else                  kill_next = ~accept;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= S_ISSUE;
      pc              <= RESET_PC;
      req_pc          <= RESET_PC;
      kill            <= 1'b0;
      buf_valid       <= 1'b0;
      buf_instr       <= NOP_INSTR;
      buf_addr        <= RESET_PC;
      valid_out       <= 1'b0;
      instruction_out <= NOP_INSTR;
      pre_address_out <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      kill  <= kill_next;
      if (grant) req_pc <= pc;
      if (redirect_valid) begin
        valid_out       <= 1'b0;
        instruction_out <= NOP_INSTR;
        buf_valid       <= 1'b0;
      end else if (stall_in) begin
        if (deliver) begin
          buf_valid <= 1'b1;
          buf_instr <= imem_rdata;
          buf_addr  <= req_pc;
        end
      end else if (buf_valid) begin
        valid_out       <= 1'b1;
        instruction_out <= buf_instr;
        pre_address_out <= buf_addr;
        buf_valid       <= 1'b0;
      end else if (deliver) begin
        valid_out       <= 1'b1;
        instruction_out <= imem_rdata;
        pre_address_out <= req_pc;
      end else begin
        valid_out       <= 1'b0;
        instruction_out <= NOP_INSTR;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - randomized bench for fetch_stage against a transaction-level model
// Memory answers each grant with addr^KEY after a chosen latency; the model predicts fetch order and outputs.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] KEY      = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall_in;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        valid_out;
  logic [31:0] instruction_out;
  logic [31:0] pre_address_out;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall_in(stall_in), .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .valid_out(valid_out), .instruction_out(instruction_out), .pre_address_out(pre_address_out)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // stimulus knobs
  int          p_gnt, p_stall, p_redir, lat_min, lat_max, redir_mode;
  bit          tgt_fixed;
  logic [31:0] tgt_val;

  // memory responder
  bit          mem_busy = 1'b0;
  int          mem_cnt  = 0;
  logic [31:0] mem_addr = '0;

  // reference model: next fetch address, one outstanding request, pending stalled deliveries
  bit          e_known = 1'b0;
  logic [31:0] m_pc;
  bit          m_out = 1'b0;
  bit          m_killed = 1'b0;
  logic [31:0] m_out_addr;
  logic [31:0] m_buf_q[$];
  bit          e_v;
  logic [31:0] e_i, e_a;

  task automatic cycle(input bit rst_v);
    bit          g, r, good, exp_req;
    logic [31:0] raddr;
    @(posedge clk); #1;
    rst         = rst_v;
    stall_in    = ($urandom_range(99) < p_stall);
    imem_gnt    = !mem_busy && ($urandom_range(99) < p_gnt);
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (mem_busy) begin
      if (mem_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_addr ^ KEY;
      end else begin
        mem_cnt--;
      end
    end
    redirect_valid = ($urandom_range(99) < p_redir);
    redirect_addr  = tgt_fixed ? tgt_val : $urandom;
    #1;
    if (redir_mode == 1 && rst_v && mem_busy && !imem_rvalid) begin
      redirect_valid = 1'b1;
      redir_mode     = 0;
    end
    if (redir_mode == 2 && rst_v && imem_req && imem_gnt) begin
      redirect_valid = 1'b1;
      redir_mode     = 0;
    end
    @(negedge clk);
    exp_req = rst && !m_out && (m_buf_q.size() == 0);
    if (!rst || e_known) check("imem_req", 32'(imem_req), 32'(exp_req));
    if (e_known && exp_req) check("imem_addr", imem_addr, m_pc);
    if (e_known) begin
      check("valid_out", 32'(valid_out), 32'(e_v));
      check("instruction_out", instruction_out, e_i);
      check("pre_address_out", pre_address_out, e_a);
    end
    if (imem_rvalid) mem_busy = 1'b0;
    if (imem_req && imem_gnt) begin
      mem_busy = 1'b1;
      mem_addr = imem_addr;
      mem_cnt  = $urandom_range(lat_max - 1, lat_min - 1);
    end
    if (!rst) begin
      m_pc     = RESET_PC;
      m_out    = 1'b0;
      m_killed = 1'b0;
      m_buf_q.delete();
      e_v      = 1'b0;
      e_i      = NOP;
      e_a      = RESET_PC;
      e_known  = 1'b1;
    end else begin
      g     = exp_req && imem_gnt;
      r     = m_out && imem_rvalid;
      good  = r && !m_killed && !redirect_valid;
      raddr = m_out_addr;
      if (r) m_out = 1'b0;
      if (g) begin
        m_out      = 1'b1;
        m_out_addr = m_pc;
        m_killed   = redirect_valid;
        m_pc       = m_pc + 32'd4;
      end else if (redirect_valid && m_out) begin
        m_killed = 1'b1;
      end
      if (redirect_valid) begin
        m_pc = redirect_addr & 32'hFFFF_FFFC;
        m_buf_q.delete();
        e_v  = 1'b0;
        e_i  = NOP;
      end else if (stall_in) begin
        if (good) m_buf_q.push_back(raddr);
      end else if (m_buf_q.size() > 0) begin
        e_a = m_buf_q.pop_front();
        e_v = 1'b1;
        e_i = e_a ^ KEY;
      end else if (good) begin
        e_v = 1'b1;
        e_i = raddr ^ KEY;
        e_a = raddr;
      end else begin
        e_v = 1'b0;
        e_i = NOP;
      end
    end
  endtask

  initial begin
    rst = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    stall_in = 1'b0; redirect_valid = 1'b0; redirect_addr = '0;
    p_gnt = 100; p_stall = 0; p_redir = 0; lat_min = 1; lat_max = 1;
    redir_mode = 0; tgt_fixed = 1'b0; tgt_val = '0;

    repeat (3) cycle(1'b0);
    repeat (12) cycle(1'b1);

    // stall while a response lands in the buffer
    p_stall = 100;
    repeat (5) cycle(1'b1);
    p_stall = 0;
    repeat (6) cycle(1'b1);

    // redirect while waiting on a slow response
    lat_min = 3; lat_max = 3; tgt_fixed = 1'b1; tgt_val = 32'h0000_0103; redir_mode = 1;
    for (int k = 0; k < 40 && redir_mode != 0; k++) cycle(1'b1);
    check("redirect_wait_fired", 32'(redir_mode), 32'd0);
    repeat (10) cycle(1'b1);

    // redirect coincident with a grant
    lat_min = 1; lat_max = 1; tgt_val = 32'h0000_0203; redir_mode = 2;
    for (int k = 0; k < 40 && redir_mode != 0; k++) cycle(1'b1);
    check("redirect_gnt_fired", 32'(redir_mode), 32'd0);
    repeat (10) cycle(1'b1);

    // PC wrap from 0xFFFF_FFFC to 0
    tgt_val = 32'hFFFF_FFFE; redir_mode = 2;
    for (int k = 0; k < 40 && redir_mode != 0; k++) cycle(1'b1);
    check("redirect_wrap_fired", 32'(redir_mode), 32'd0);
    repeat (10) cycle(1'b1);

    // reset while a response is owed; the stale rvalid lands after release
    tgt_fixed = 1'b0; lat_min = 6; lat_max = 6;
    for (int k = 0; k < 40 && !mem_busy; k++) cycle(1'b1);
    check("reset_in_wait_reached", 32'(mem_busy), 32'd1);
    repeat (2) cycle(1'b0);
    repeat (16) cycle(1'b1);

    // random soak
    p_gnt = 70; p_stall = 30; p_redir = 8; lat_min = 1; lat_max = 4;
    for (int k = 0; k < 4000; k++) cycle(($urandom_range(999) < 5) ? 1'b0 : 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
